// File: rtl/riv_rdy_vld_fifo.sv
// riv_rdy_vld_fifo
//   Synchronous ready/valid FIFO that sits directly in front of a ready/valid
//   sink. It absorbs producer bursts while the sink holds off m_ready.
//   s_ready and m_valid are decoded only from the registered occupancy, so
//   there is no combinational path from m_ready to s_ready. A word is never
//   passed straight through when the FIFO is empty; minimum latency is 1 cycle.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   s_valid  in   upstream word present on s_data
//   s_ready  out  FIFO accepts a word this cycle (not full)
//   s_data   in   upstream payload
//   m_valid  out  head word presented to the sink (not empty)
//   m_ready  in   sink accepts the head word
//   m_data   out  head payload, zero while m_valid=0
//   level    out  occupancy 0..DEPTH
//   full     out  level == DEPTH
//   empty    out  level == 0
module riv_rdy_vld_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_WIDTH-1:0]    s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);

    // Handshakes are qualified by the registered flags only; a pop while full
    // does not open s_ready until the following cycle.
    assign w_push = s_valid & ~w_full & ~rst;
    assign w_pop  = m_ready & ~w_empty & ~rst;

    // Storage is deliberately left out of reset; level gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign s_ready = ~w_full;
    assign m_valid = ~w_empty;
    assign m_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign level   = r_level;
    assign full    = w_full;
    assign empty   = w_empty;

endmodule

// File: tb/tb_riv_rdy_vld_fifo.sv
// tb_riv_rdy_vld_fifo
//   Self-checking bench: a queue-based reference model predicts every output
//   each cycle; directed scenarios plus a randomized 1000-word run.
module tb_riv_rdy_vld_fifo;

    localparam int DW    = 64;
    localparam int DEPTH = 4;

    logic                   clk;
    logic                   rst;
    logic                   s_valid;
    logic                   s_ready;
    logic [DW-1:0]          s_data;
    logic                   m_valid;
    logic                   m_ready;
    logic [DW-1:0]          m_data;
    logic [$clog2(DEPTH):0] level;
    logic                   full;
    logic                   empty;

    riv_rdy_vld_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .level  (level),
        .full   (full),
        .empty  (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mdl_q [$];   // reference contents, head at index 0
    logic [DW-1:0] obs_q [$];   // words the DUT actually handed to the sink
    logic          pv_hold = 1'b0;
    logic [DW-1:0] pv_data = '0;
    int            n_push  = 0;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Called at the falling edge: check outputs against the model, drive the
    // inputs, advance the model across the next rising edge.
    task automatic cyc(input logic r, input logic sv, input logic [DW-1:0] sd, input logic mr);
        int  sz;
        bit  p_push;
        bit  p_pop;
        sz = mdl_q.size();
        chk("s_ready", {63'd0, s_ready}, {63'd0, sz < DEPTH});
        chk("m_valid", {63'd0, m_valid}, {63'd0, sz > 0});
        chk("m_data",  m_data, (sz > 0) ? mdl_q[0] : '0);
        chk("level",   {61'd0, level}, DW'(sz));
        chk("full",    {63'd0, full},  {63'd0, sz == DEPTH});
        chk("empty",   {63'd0, empty}, {63'd0, sz == 0});
        if (pv_hold) begin
            chk("hold_valid", {63'd0, m_valid}, 64'd1);
            chk("hold_data",  m_data, pv_data);
        end
        rst = r; s_valid = sv; s_data = sd; m_ready = mr;
        if (!r && m_valid && mr) obs_q.push_back(m_data);
        pv_hold = !r && m_valid && !mr;
        pv_data = m_data;
        if (r) begin
            mdl_q.delete();
        end else begin
            p_push = sv && (sz < DEPTH);
            p_pop  = mr && (sz > 0);
            if (p_pop)  void'(mdl_q.pop_front());
            if (p_push) begin
                mdl_q.push_back(sd);
                n_push++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int bound);
        int k;
        k = 0;
        while (mdl_q.size() > 0 && k < bound) begin
            cyc(1'b0, 1'b0, '0, 1'b1);
            k++;
        end
        chk("drain_bound", DW'(mdl_q.size()), '0);
    endtask

    task automatic chk_seq(input string tag, input logic [DW-1:0] exp [$]);
        chk({tag, "_len"}, DW'(obs_q.size()), DW'(exp.size()));
        for (int i = 0; i < exp.size() && i < obs_q.size(); i++) chk(tag, obs_q[i], exp[i]);
    endtask

    initial begin
        logic [DW-1:0] e [$];
        int guard;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // 1: reset then idle
        chk("t1_level",   DW'(level), '0);
        chk("t1_m_valid", DW'(m_valid), '0);
        chk("t1_m_data",  m_data, '0);
        chk("t1_s_ready", DW'(s_ready), 64'd1);
        chk("t1_empty",   DW'(empty), 64'd1);
        cyc(1'b0, 1'b0, '0, 1'b0);

        // 2: single word, latency 1, popped next edge
        obs_q.delete();
        cyc(1'b0, 1'b1, 64'hA5, 1'b1);
        chk("t2_m_valid", DW'(m_valid), 64'd1);
        chk("t2_m_data",  m_data, 64'hA5);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("t2_level",   DW'(level), '0);
        e = {64'hA5};
        chk_seq("t2_out", e);

        // 3: fill under back-pressure, 5th word held upstream, then drain
        obs_q.delete();
        for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b1, DW'(i), 1'b0);
        chk("t3_level",   DW'(level), 64'd4);
        chk("t3_full",    DW'(full), 64'd1);
        chk("t3_s_ready", DW'(s_ready), '0);
        cyc(1'b0, 1'b1, 64'd5, 1'b1);
        chk("t3_refused_level", DW'(level), 64'd3);
        cyc(1'b0, 1'b1, 64'd5, 1'b1);
        drain(10);
        e = {64'd1, 64'd2, 64'd3, 64'd4, 64'd5};
        chk_seq("t3_out", e);

        // 4: full plus simultaneous offer
        obs_q.delete();
        for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, DW'(i), 1'b0);
        cyc(1'b0, 1'b1, 64'h99, 1'b1);
        chk("t4_level_a", DW'(level), 64'd3);
        cyc(1'b0, 1'b1, 64'h99, 1'b0);
        chk("t4_level_b", DW'(level), 64'd4);
        drain(10);
        e = {64'd1, 64'd2, 64'd3, 64'd4, 64'h99};
        chk_seq("t4_out", e);

        // 5: streaming through the wrap
        obs_q.delete();
        e.delete();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, DW'(64'h100 + i), 1'b1);
            chk("t5_level", DW'(level), 64'd1);
            e.push_back(DW'(64'h100 + i));
        end
        drain(4);
        chk_seq("t5_out", e);

        // 6: reset mid-burst discards contents and ignores the reset-cycle requests
        obs_q.delete();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, DW'(64'hDEAD0 + i), 1'b0);
        chk("t6_level_pre", DW'(level), 64'd3);
        cyc(1'b1, 1'b1, 64'hBAD, 1'b1);
        chk("t6_level",   DW'(level), '0);
        chk("t6_m_valid", DW'(m_valid), '0);
        cyc(1'b0, 1'b1, 64'h77, 1'b0);
        drain(4);
        e = {64'h77};
        chk_seq("t6_out", e);

        // Random traffic: 1000 words, random valid/ready
        n_push = 0;
        guard  = 0;
        while (n_push < 1000 && guard < 20000) begin
            cyc(1'b0, ($urandom_range(0, 3) != 0), {$urandom, $urandom},
                ($urandom_range(0, 2) != 0));
            guard++;
        end
        chk("rand_bound", DW'(n_push), 64'd1000);
        drain(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
